// File: rtl/i2c_cfg_sequencer_if.sv
// Handshake bundle between the codec config sequencer and the I2C master.
// Ports: go, i2c_busy in; i2c_start, i2c_data, index, active, done, err out.
interface i2c_cfg_sequencer_if;
  logic        go;
  logic        i2c_busy;
  logic        i2c_start;
  logic [15:0] i2c_data;
  logic [2:0]  index;
  logic        active;
  logic        done;
  logic        err;

  modport master (
    input  go,
    input  i2c_busy,
    output i2c_start,
    output i2c_data,
    output index,
    output active,
    output done,
    output err
  );

  modport slave (
    output go,
    output i2c_busy,
    input  i2c_start,
    input  i2c_data,
    input  index,
    input  active,
    input  done,
    input  err
  );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Codec config sequencer: power-up wait, then feeds a fixed register table to the I2C master.
// Ports: CLK, RST_N (async low); bus (master modport) carries go/busy in, start/data/status out.
module i2c_cfg_sequencer #(
  parameter int NUM_REGS      = 8,
  parameter int POWERUP_DELAY = 50000,
  parameter int GAP_CYCLES    = 16,
  parameter int BUSY_TIMEOUT  = 1024
) (
  input logic                 CLK,
  input logic                 RST_N,
  i2c_cfg_sequencer_if.master bus
);

  localparam int PW = $clog2(POWERUP_DELAY) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_DELAY - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] REQ_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_PWR,
    S_LOAD,
    S_REQ,
    S_XFER,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t        r_state, w_state;
  logic [PW-1:0] r_pwr, w_pwr;
  logic [GW-1:0] r_gap, w_gap;
  logic [TW-1:0] r_req, w_req;
  logic          r_start, w_start;
  logic [15:0]   r_data, w_data;
  logic [2:0]    r_index, w_index;
  logic          r_done, r_err, r_active;

  function automatic logic [15:0] f_table(input logic [2:0] i);
    logic [15:0] v;
    unique case (i)
      3'd0: v = 16'h1E00;
      3'd1: v = 16'h0C00;
      3'd2: v = 16'h0E42;
      3'd3: v = 16'h1001;
      3'd4: v = 16'h0817;
      3'd5: v = 16'h0A06;
      3'd6: v = 16'h0012;
      3'd7: v = 16'h0201;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  always_comb begin
    w_state = r_state;
    w_pwr   = r_pwr;
    w_gap   = r_gap;
    w_req   = r_req;
    w_start = r_start;
    w_data  = r_data;
    w_index = r_index;
    unique case (r_state)
      S_PWR: begin
        if (r_pwr == PWR_LAST) begin
          w_state = S_LOAD;
          w_pwr   = '0;
        end else begin
          w_pwr = r_pwr + 1'b1;
        end
      end
      S_LOAD: begin
        w_data  = f_table(r_index);
        w_req   = '0;
        w_state = S_REQ;
      end
      S_REQ: begin
        // start rises on the first REQ edge; busy is only honoured
        // once start is visible, so a stuck-high busy yields a 1-cycle pulse
        if (!r_start) begin
          w_start = 1'b1;
        end else if (bus.i2c_busy) begin
          w_start = 1'b0;
          w_state = S_XFER;
        end else if (r_req == REQ_LAST) begin
          w_start = 1'b0;
          w_state = S_ERR;
        end else begin
          w_req = r_req + 1'b1;
        end
      end
      S_XFER: begin
        if (!bus.i2c_busy) begin
          w_gap   = '0;
          w_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          if (r_index == IDX_LAST) begin
            w_state = S_DONE;
          end else begin
            w_index = r_index + 3'd1;
            w_state = S_LOAD;
          end
        end else begin
          w_gap = r_gap + 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        if (bus.go) begin
          w_index = 3'd0;
          w_state = S_LOAD;
        end
      end
      default: w_state = S_PWR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_PWR;
      r_pwr    <= '0;
      r_gap    <= '0;
      r_req    <= '0;
      r_start  <= 1'b0;
      r_data   <= 16'h0000;
      r_index  <= 3'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_active <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_pwr    <= w_pwr;
      r_gap    <= w_gap;
      r_req    <= w_req;
      r_start  <= w_start;
      r_data   <= w_data;
      r_index  <= w_index;
      r_done   <= (w_state == S_DONE);
      r_err    <= (w_state == S_ERR);
      r_active <= (w_state != S_DONE) && (w_state != S_ERR);
    end
  end

  assign bus.i2c_start = r_start;
  assign bus.i2c_data  = r_data;
  assign bus.index     = r_index;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.active    = r_active;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer with a behavioural I2C master.
// Main DUT runs the full table; a second DUT uses a one-entry table.
module tb_i2c_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b1;
  logic rst1_n = 1'b1;
  logic go     = 1'b0;
  logic master_en = 1'b1;

  i2c_cfg_sequencer_if bus ();
  i2c_cfg_sequencer_if bus1 ();

  i2c_cfg_sequencer #(
    .NUM_REGS(8), .POWERUP_DELAY(20),
    .GAP_CYCLES(4), .BUSY_TIMEOUT(8)
  ) u_dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus)
  );

  i2c_cfg_sequencer #(
    .NUM_REGS(1), .POWERUP_DELAY(20),
    .GAP_CYCLES(4), .BUSY_TIMEOUT(8)
  ) u_dut1 (
    .CLK(clk), .RST_N(rst1_n), .bus(bus1)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  logic [15:0] exp_tab [8] = '{16'h1E00, 16'h0C00, 16'h0E42, 16'h1001,
                               16'h0817, 16'h0A06, 16'h0012, 16'h0201};
  logic [15:0] starts_q [$];
  logic [15:0] starts1_q [$];

  // behavioural master: busy rises 2 cycles after start is seen, held 10
  logic m_busy  = 1'b0;
  int   m_phase = 0;
  int   m_cnt   = 0;
  logic m1_busy  = 1'b0;
  int   m1_phase = 0;
  int   m1_cnt   = 0;

  assign bus.i2c_busy  = m_busy;
  assign bus.go        = go;
  assign bus1.i2c_busy = m1_busy;
  assign bus1.go       = 1'b0;

  always @(posedge clk) begin
    if (m_phase == 0) begin
      if (bus.i2c_start === 1'b1 && master_en) begin
        m_phase <= 1;
        m_cnt   <= 0;
      end
    end else if (m_phase == 1) begin
      if (m_cnt == 1) begin
        m_busy  <= 1'b1;
        m_phase <= 2;
        m_cnt   <= 0;
      end else m_cnt <= m_cnt + 1;
    end else begin
      if (m_cnt == 9) begin
        m_busy  <= 1'b0;
        m_phase <= 0;
      end else m_cnt <= m_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (m1_phase == 0) begin
      if (bus1.i2c_start === 1'b1) begin
        m1_phase <= 1;
        m1_cnt   <= 0;
      end
    end else if (m1_phase == 1) begin
      if (m1_cnt == 1) begin
        m1_busy  <= 1'b1;
        m1_phase <= 2;
        m1_cnt   <= 0;
      end else m1_cnt <= m1_cnt + 1;
    end else begin
      if (m1_cnt == 9) begin
        m1_busy  <= 1'b0;
        m1_phase <= 0;
      end else m1_cnt <= m1_cnt + 1;
    end
  end

  // record the data word at every start rise
  logic prev_start  = 1'b0;
  logic prev1_start = 1'b0;
  always @(negedge clk) begin
    if (bus.i2c_start === 1'b1 && prev_start !== 1'b1)
      starts_q.push_back(bus.i2c_data);
    if (bus1.i2c_start === 1'b1 && prev1_start !== 1'b1)
      starts1_q.push_back(bus1.i2c_data);
    prev_start  <= bus.i2c_start;
    prev1_start <= bus1.i2c_start;
  end

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_xfer(input logic [2:0] idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.index === idx && bus.i2c_busy === 1'b1 &&
          bus.i2c_start === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    n_asserts++;
    if (bus.i2c_start !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: got %b want 0", tag, bus.i2c_start);
    end
    n_asserts++;
    if (bus.i2c_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL %s data: got %h want 0000", tag, bus.i2c_data);
    end
    n_asserts++;
    if (bus.index !== 3'd0) begin
      n_fail++;
      $display("FAIL %s index: got %0d want 0", tag, bus.index);
    end
    n_asserts++;
    if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done/err: got %b%b want 00", tag, bus.done, bus.err);
    end
    n_asserts++;
    if (bus.active !== 1'b1) begin
      n_fail++;
      $display("FAIL %s active: got %b want 1", tag, bus.active);
    end
  endtask

  task automatic chk_run(input string tag);
    bit ok;
    wait_done(ok);
    n_asserts++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s done_timeout: got done=%b want 1", tag, bus.done);
    end
    n_asserts++;
    if (starts_q.size() != 8) begin
      n_fail++;
      $display("FAIL %s start_count: got %0d want 8", tag, starts_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < starts_q.size()) begin
        n_asserts++;
        if (starts_q[i] !== exp_tab[i]) begin
          n_fail++;
          $display("FAIL %s word%0d: got %h want %h",
                   tag, i, starts_q[i], exp_tab[i]);
        end
      end
    end
    n_asserts++;
    if (bus.active !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s active/err: got %b%b want 00",
               tag, bus.active, bus.err);
    end
    n_asserts++;
    if (bus.index !== 3'd7) begin
      n_fail++;
      $display("FAIL %s index: got %0d want 7", tag, bus.index);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    rst1_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
  endtask

  task automatic test_powerup();
    int n = 0;
    starts_q.delete();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.i2c_start === 1'b1) begin
        n = i;
        break;
      end
    end
    n_asserts++;
    if (n != 22) begin
      n_fail++;
      $display("FAIL powerup_latency: got %0d want 22", n);
    end
    n_asserts++;
    if (bus.i2c_data !== 16'h1E00) begin
      n_fail++;
      $display("FAIL powerup_data: got %h want 1E00", bus.i2c_data);
    end
  endtask

  task automatic test_full_run();
    chk_run("full_run");
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit seen = 1'b0;
    master_en = 1'b0;
    starts_q.delete();
    pulse_go();
    for (int i = 0; i < 50; i++) begin
      if (bus.i2c_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    while (seen && bus.i2c_start === 1'b1 && hi < 50) begin
      @(negedge clk);
      hi++;
    end
    n_asserts++;
    if (hi != 8) begin
      n_fail++;
      $display("FAIL timeout_start_high: got %0d want 8", hi);
    end
    @(negedge clk);
    n_asserts++;
    if (bus.err !== 1'b1 || bus.active !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_flags: got err=%b act=%b done=%b want 1 0 0",
               bus.err, bus.active, bus.done);
    end
    n_asserts++;
    if (bus.index !== 3'd0) begin
      n_fail++;
      $display("FAIL timeout_index: got %0d want 0", bus.index);
    end
    repeat (30) @(negedge clk);
    n_asserts++;
    if (starts_q.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_starts: got %0d want 1", starts_q.size());
    end
  endtask

  task automatic test_go_from_err();
    master_en = 1'b1;
    starts_q.delete();
    pulse_go();
    n_asserts++;
    if (bus.err !== 1'b0 || bus.active !== 1'b1) begin
      n_fail++;
      $display("FAIL go_err_clear: got err=%b act=%b want 0 1",
               bus.err, bus.active);
    end
    chk_run("go_from_err");
  endtask

  task automatic test_reset_xfer();
    bit ok;
    starts_q.delete();
    pulse_go();
    wait_xfer(3'd3, ok);
    n_asserts++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_xfer_reach: got 0 want 1");
    end
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("reset_xfer");
    repeat (3) @(negedge clk);
    starts_q.delete();
    rst_n = 1'b1;
    chk_run("reset_xfer_rerun");
  endtask

  task automatic test_go_ignored();
    bit ok;
    starts_q.delete();
    pulse_go();
    wait_xfer(3'd1, ok);
    n_asserts++;
    if (!ok) begin
      n_fail++;
      $display("FAIL go_ignored_reach: got 0 want 1");
    end
    pulse_go();
    chk_run("go_ignored");
  endtask

  task automatic test_num_regs_1();
    bit ok = 1'b0;
    starts1_q.delete();
    @(negedge clk) rst1_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus1.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_asserts++;
    if (!ok) begin
      n_fail++;
      $display("FAIL one_reg_done: got %b want 1", bus1.done);
    end
    n_asserts++;
    if (starts1_q.size() != 1) begin
      n_fail++;
      $display("FAIL one_reg_starts: got %0d want 1", starts1_q.size());
    end else begin
      n_asserts++;
      if (starts1_q[0] !== 16'h1E00) begin
        n_fail++;
        $display("FAIL one_reg_word: got %h want 1E00", starts1_q[0]);
      end
    end
    n_asserts++;
    if (bus1.index !== 3'd0 || bus1.active !== 1'b0) begin
      n_fail++;
      $display("FAIL one_reg_state: got idx=%0d act=%b want 0 0",
               bus1.index, bus1.active);
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_full_run();
    test_timeout();
    test_go_from_err();
    test_reset_xfer();
    test_go_ignored();
    test_num_regs_1();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
